uart_rx: RTL
============

Name: uart_rx

Overview:
8N1 UART receiver that pairs with the existing UART transmitter on the same Tiny Tapeout tile.
- Synchronises the asynchronous serial input and detects the start bit.
- Samples each bit at mid-bit and delivers the received byte through a single-entry valid/ready holding register.
- Flags framing errors and overruns.
- Serves as the loopback and host-command path for the tile: rx is driven from a uio input pin, and data drives uo_out/status.

Parameters:
CLKS_PER_BIT, 100, clock cycles per bit (100 MHz / 1 Mbaud); must be >= 4.
DATA_BITS, 8, data bits per frame, LSB first; no parity, one stop bit.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous reset, active-high.
rx  in  1  asynchronous serial line; idle high.
data  out  DATA_BITS  received byte; valid while data_valid=1.
data_valid  out  1  holding register full.
data_ready  in  1  consumer accepts the byte on a cycle where data_valid&data_ready.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
overrun  out  1  sticky: a complete frame arrived while the holding register was full and not being accepted.
clr_err  in  1  clears overrun; takes priority over a same-cycle set.
busy  out  1  high in any state other than IDLE.

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high, sampled only on the rising edge of clk.

Reset values:
- Synchroniser flops = 1.
- State = IDLE; counters = 0; data = 0.
- data_valid = 0, frame_err = 0, overrun = 0, busy = 0.
- A reset mid-frame abandons the frame. No valid or error is produced for it.

Synchroniser:
- Two flops; rx_s is the second flop.
- Latency from the rx pin to rx_s is 2 cycles.

FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rx_s=0, go to START and clear the baud counter.
- START: count to CLKS_PER_BIT/2 (integer division).
  - If rx_s=1 at that sample, it is a false start: return to IDLE.
  - Otherwise clear the counter and the bit index, then go to DATA.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit [bit_idx] (LSB first).
  - After sample DATA_BITS-1, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - If 1, the frame is good: push it to the holding register and go to IDLE.
  - If 0, pulse frame_err for 1 cycle, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. A break condition therefore never retriggers a frame.

Latency:
- The good-frame push happens on the stop-sample cycle. data_valid rises the following cycle.
- Measured from the rx falling edge, data_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles later, which is 953 at the default (±1 for input phase).
- The receiver is back in IDLE at mid-stop-bit, so back-to-back frames are accepted.

Holding register rules:
- A push with data_valid=0 loads data and sets data_valid.
- Accept without push: data_valid clears the next cycle.
- Push and accept in the same cycle: the new byte loads and data_valid stays 1, with no overrun.
- Push while data_valid=1 and no accept: the new byte is dropped, the old byte is kept, and overrun sets.
- data stays stable while data_valid=1 and not accepted.

Decomposition:
- Package uart_pkg holds:
  - the state encoding (rx_state_t: IDLE, START, DATA, STOP, WAIT_HIGH);
  - the defaults CLKS_PER_BIT_DEF=100 and DATA_BITS_DEF=8;
  - the shared constants IDLE_LEVEL=1 and STOP_LEVEL=1.
- The transmitter reuses the same package.
- One sub-module: uart_sync2, the two-flop synchroniser. Its reset value is a parameter, set to 1 here.

Test Plan:
- 0x55 at 100 clk/bit, data_ready=1 → data_valid pulses 1 cycle with data=0x55 at cycle 953 ±1 after the start edge; frame_err=0, overrun=0.
- 0x55 then 0xA5 back-to-back, data_ready held 0 until 20 cycles after the second frame, then 1 → data=0x55 stays held; overrun sets at the second push; 0xA5 is never presented; clr_err clears overrun.
- Frame with stop bit forced 0 (0xA5) → frame_err 1-cycle pulse, data_valid stays 0, busy=1 until rx returns high.
- 30-cycle low glitch on idle rx → false start; busy returns to 0 around cycle 52; no valid or error.
- rst asserted at data bit 4 of 0xA5 → all outputs 0 the next cycle; a subsequent clean 0x3C is received correctly.
- data_ready asserted on the exact push cycle for a second frame while the first is valid → 0x55 accepted, 0xA5 loaded, data_valid continuous, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame timing and line levels.
// The transmitter on the same tile imports this package too.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 100;
  localparam int DATA_BITS_DEF    = 8;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input.
// The reset value is chosen by the instantiating block so that reset looks like a quiet line.
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = IDLE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, single-entry valid/ready holding register,
// framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     bit_idx, idx_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 sample, push, ferr_set, accept;

  uart_sync2 #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= idx_next;
      frame_err <= ferr_set;
      if (sample) shift_reg[bit_idx] <= rx_s;
    end
  end

  // The baud counter restarts at every sample point so each phase counts from zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    idx_next   = bit_idx;
    sample     = 1'b0;
    push       = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rx_s != IDLE_LEVEL) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = (rx_s == IDLE_LEVEL) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          sample   = 1'b1;
          if (bit_idx == IDX_LAST) state_next = STOP;
          else                     idx_next   = bit_idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s == STOP_LEVEL) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_next = '0;
        if (rx_s == IDLE_LEVEL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = data_valid & data_ready;
  assign busy   = (state != IDLE);

  // A push into a full, unaccepted register keeps the old byte and flags overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (push && (!data_valid || accept)) begin
        data       <= shift_reg;
        data_valid <= 1'b1;
      end else if (accept) begin
        data_valid <= 1'b0;
      end
      if (clr_err)                           overrun <= 1'b0;
      else if (push && data_valid && !accept) overrun <= 1'b1;
    end
  end

endmodule
